// File: rtl/bin2bcd_seq_ctrl.sv
`default_nettype none
// ---- bin2bcd_seq_ctrl : sequential double-dabble binary-to-BCD converter, one shift per clock (rev 1.0) ----
module bin2bcd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_corr;
  logic [BW-1:0]    bcd_nx;
  logic             ovf_acc;
  logic             ovf_nx;
  logic [CW-1:0]    cnt;

  // Add-3 correction on every digit in parallel, ahead of the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
    assign bcd_corr[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? (bcd[4*gi +: 4] + 4'd3)
                                                          : bcd[4*gi +: 4];
  end

  assign bcd_nx = {bcd_corr[BW-2:0], bin[WIDTH-1]};
  assign ovf_nx = ovf_acc | bcd_corr[BW-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin     <= '0;
      bcd     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      out_bcd <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin     <= in_data;
            bcd     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          bin     <= bin << 1;
          bcd     <= bcd_nx;
          ovf_acc <= ovf_nx;
          cnt     <= cnt + CW'(1);
          // Final step: publish the result on the same edge that enters DONE.
          if (cnt == LAST) begin
            out_bcd <= bcd_nx;
            out_ovf <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq_ctrl.sv
`default_nettype none
// Scoreboard bench for bin2bcd_seq_ctrl: 3-digit instance plus a 2-digit overflow instance.
module tb_bin2bcd_seq_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  in_a  = '0;
  logic        iv_a  = 1'b0;
  logic        ir_a;
  logic [11:0] bcd_a;
  logic        ovf_a;
  logic        ov_a;
  logic        or_a  = 1'b0;
  logic        busy_a;

  logic [7:0]  in_b  = '0;
  logic        iv_b  = 1'b0;
  logic        ir_b;
  logic [7:0]  bcd_b;
  logic        ovf_b;
  logic        ov_b;
  logic        or_b  = 1'b1;
  logic        busy_b;

  bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_a), .in_valid(iv_a), .in_ready(ir_a),
    .out_bcd(bcd_a), .out_ovf(ovf_a), .out_valid(ov_a), .out_ready(or_a), .busy(busy_a)
  );

  bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_b), .in_valid(iv_b), .in_ready(ir_b),
    .out_bcd(bcd_b), .out_ovf(ovf_b), .out_valid(ov_b), .out_ready(or_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_iss = 0;
  int n_got = 0;
  int dly_lo = 0;
  int dly_hi = 0;
  int wait_a = -1;

  logic [12:0] exp_a[$];
  int          acc_a[$];
  logic [8:0]  exp_b[$];
  logic [12:0] ea;
  logic [8:0]  eb;
  logic        prev_v = 1'b0;
  logic [12:0] prev_o = '0;

  always @(posedge clk) cyc++;

  // Reference: digit i = (v / 10^i) % 10; overflow when v >= 10^digits. Returns {ovf, bcd}.
  function automatic logic [12:0] ref_conv(input int v, input int digits);
    logic [11:0] r = '0;
    int p = 1;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return {(v >= p), r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event, expected none", nm);
  endtask

  // Consumer for instance A: raise out_ready a random number of cycles after out_valid.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      or_a   = 1'b0;
      wait_a = -1;
    end else if (ov_a && !or_a) begin
      if (wait_a < 0) wait_a = int'($urandom_range(dly_hi, dly_lo));
      if (wait_a == 0) begin
        or_a   = 1'b1;
        wait_a = -1;
      end else begin
        wait_a--;
      end
    end else begin
      or_a = 1'b0;
    end
  end

  // Monitor A: latency, in_ready during SHIFT, hold stability, result vs scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_a) chk("in_ready_in_shift", 32'(ir_a), 32'(0));
      if (ov_a && !prev_v) begin
        if (acc_a.size() == 0) flag("valid_without_accept");
        else chk("latency", 32'(cyc - acc_a.pop_front()), 32'(W + 1));
      end
      if (ov_a && prev_v) chk("hold_stable", 32'({ovf_a, bcd_a}), 32'(prev_o));
      if (ov_a && or_a) begin
        if (exp_a.size() == 0) flag("duplicate_result");
        else begin
          ea = exp_a.pop_front();
          chk("result_a", 32'({ovf_a, bcd_a}), 32'(ea));
          n_got++;
        end
      end
    end
    prev_v = ov_a && !rst;
    prev_o = {ovf_a, bcd_a};
  end

  // Monitor B: overflow flag always, digits only when the result is in range.
  always @(negedge clk) begin
    if (!rst && ov_b && or_b) begin
      if (exp_b.size() == 0) flag("duplicate_result_b");
      else begin
        eb = exp_b.pop_front();
        chk("ovf_b", 32'(ovf_b), 32'(eb[8]));
        if (!eb[8]) chk("bcd_b", 32'(bcd_b), 32'(eb[7:0]));
      end
    end
  end

  task automatic send_a(input logic [7:0] v);
    int n = 0;
    in_a = v;
    iv_a = 1'b1;
    @(negedge clk);
    while (!ir_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir_a) flag("accept_timeout_a");
    else begin
      exp_a.push_back(ref_conv(int'(v), 3));
      acc_a.push_back(cyc);
      n_iss++;
    end
    @(posedge clk);
    #1;
    iv_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    int n = 0;
    logic [12:0] r;
    in_b = v;
    iv_b = 1'b1;
    @(negedge clk);
    while (!ir_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir_b) flag("accept_timeout_b");
    else begin
      r = ref_conv(int'(v), 2);
      exp_b.push_back({r[12], r[7:0]});
    end
    @(posedge clk);
    #1;
    iv_b = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_a.size() != 0 || exp_b.size() != 0) flag("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(ir_a), 32'(1));
    chk("rst_out_valid", 32'(ov_a), 32'(0));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_out_bcd", 32'(bcd_a), 32'(0));
    chk("rst_out_ovf", 32'(ovf_a), 32'(0));
    @(posedge clk);
    #1;

    // Boundary values
    send_a(8'd0);
    send_a(8'd99);
    send_a(8'd100);
    send_a(8'd255);
    drain();

    // Back-pressure: 42 offered throughout the 173 conversion, result held 6 cycles
    dly_lo = 6;
    dly_hi = 6;
    send_a(8'd173);
    send_a(8'd42);
    drain();
    dly_lo = 0;
    dly_hi = 0;

    // Reset during SHIFT: conversion of 200 must be discarded
    send_a(8'd200);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_a.pop_back());
    void'(acc_a.pop_back());
    n_iss--;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(ir_a), 32'(1));
    chk("midrst_out_valid", 32'(ov_a), 32'(0));
    chk("midrst_busy", 32'(busy_a), 32'(0));
    chk("midrst_out_bcd", 32'(bcd_a), 32'(0));
    @(posedge clk);
    #1;
    send_a(8'd137);
    drain();

    // Overflow instance (2 digits)
    send_b(8'd99);
    send_b(8'd100);
    send_b(8'd255);
    send_b(8'd7);
    drain();

    // Randomised sweep with random consumer delays
    dly_lo = 0;
    dly_hi = 5;
    for (int i = 0; i < 1000; i++) send_a(8'($urandom_range(255, 0)));
    drain();

    chk("issued_vs_received", 32'(n_got), 32'(n_iss));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
- Sequential double-dabble (shift-add-3) converter with controller: binary operand in, packed BCD result out, over ready/valid handshakes on both sides.
- Replaces the combinational binary-to-BCD datapath wherever timing or area matters. Uses one shift step per clock.
- Feeds display/readout logic that takes packed BCD digits.

Parameters:
- WIDTH, 8, binary operand width in bits.
- DIGITS, 3, number of BCD digits in the result. Digit 0 is the least significant.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  WIDTH  binary operand
- in_valid  input  1  operand offered
- in_ready  output  1  converter can accept an operand
- out_bcd  output  4*DIGITS  packed BCD result; digit i is at bits [4i+3:4i]
- out_ovf  output  1  result exceeds 10^DIGITS-1; out_bcd is then invalid
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- All state is updated on the rising edge of clk. Reset is sampled only on that edge.
- rst=1 wins over every other input and applies in any state, including mid-conversion. On the next edge:
  - state=IDLE
  - out_bcd=0, out_ovf=0, out_valid=0, busy=0, in_ready=1
  - step counter=0, internal shift register=0
  - any conversion in flight is discarded with no output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch in_data into the binary shift register; clear the BCD accumulator, the overflow flag and the step counter; go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge performs one step in this order:
    1. Every BCD digit >=5 gets +3, all digits corrected in parallel.
    2. The concatenation {bcd, bin} shifts left by 1.
    3. The bit shifted out of the top digit is ORed into the sticky overflow flag.
    4. The counter increments.
  - After the WIDTH-th step, go to DONE. out_bcd and out_ovf load from the accumulator on that same edge.
- DONE:
  - out_valid=1, in_ready=0, busy=0.
  - out_bcd and out_ovf are held stable while out_valid=1 and out_ready=0, for any duration.
  - On an edge with out_ready=1: go to IDLE; out_valid drops on that edge. out_bcd keeps its last value until the next conversion completes.
- Latency: operand accepted at edge k; out_valid=1 in the cycle after edge k+WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput: at most one conversion per WIDTH+2 cycles. No accept occurs in the cycle DONE exits; that is intended.
- in_valid is ignored outside IDLE. The operand is never sampled except on the accepting edge, so in_data may change during SHIFT without effect.
- Overflow:
  - Never asserts when DIGITS >= ceil(WIDTH*log10(2)).
  - Otherwise it asserts exactly when the operand is >= 10^DIGITS.
- Counter width: clog2(WIDTH+1). The counter never wraps.
- All digit corrections use 4-bit arithmetic. Corrected digits never exceed 4'd12 before the shift.

Test Plan:
- Reset and idle: hold rst 3 cycles, then release → in_ready=1, out_valid=0, busy=0, out_bcd=12'h000, out_ovf=0.
- Boundary values, default params:
  - 8'd0 → 12'h000
  - 8'd99 → 12'h099
  - 8'd100 → 12'h100
  - 8'd255 → 12'h255
  - For each: out_valid exactly 8 cycles after the accept edge, out_ovf=0.
- Back-pressure and busy:
  - Accept 8'd173, then keep in_valid=1 with in_data=8'd42 throughout SHIFT → in_ready=0 for the whole conversion, result 12'h173.
  - Hold out_ready=0 for 6 cycles → 12'h173 held stable with out_valid=1.
  - Assert out_ready → IDLE next edge, then 42 is accepted → 12'h042.
- Reset mid-operation: accept 8'd200, assert rst on the 4th SHIFT edge → next cycle IDLE, out_valid=0, out_bcd=0. Then convert 8'd137 → 12'h137.
- Overflow variant with WIDTH=8, DIGITS=2:
  - 8'd99 → 8'h99, out_ovf=0
  - 8'd100 → out_ovf=1
  - 8'd255 → out_ovf=1
  - Then 8'd7 → 8'h07, out_ovf=0, confirming the sticky flag clears per conversion.
- Randomised sweep: 1000 random operands with random out_ready delays of 0–5 cycles. Compare each result against a reference model: digit i = (value/10^i)%10. Check that no result is lost or duplicated.
